// File: rtl/jk_ff_monitor_pkg.sv
// Shared definitions for the JK flop monitor and predictor.
// Provides the FSM state encoding, the JK drive codes and the JK next-state rule.
// Contents: state_e, JK_* constants, jk_next().
package jk_ff_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_TRACK = 2'd2
  } state_e;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Next q of a JK flop given its present q and the {j,k} drive.
  function automatic logic jk_next(input logic q, input logic [1:0] jk);
    logic nq;
    nq = q;
    case (jk)
      JK_HOLD:   nq = q;
      JK_RESET:  nq = 1'b0;
      JK_SET:    nq = 1'b1;
      JK_TOGGLE: nq = ~q;
      default:   nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_ff_monitor_predict.sv
// Combinational JK next-state predictor, reusable by other JK-based checkers.
// Ports: i_q_r/i_j_r/i_k_r = previously captured q, j, k; o_exp_q = predicted q.
// Zero latency, no flow control.
module jk_predict
  import jk_ff_monitor_pkg::*;
(
  input  logic i_q_r,
  input  logic i_j_r,
  input  logic i_k_r,
  output logic o_exp_q
);

  assign o_exp_q = jk_next(i_q_r, {i_j_r, i_k_r});

endmodule

// File: rtl/jk_ff_monitor.sv
// Observer for a JK flop: captures j/k/q each cycle, predicts the next q and
// counts mismatches (saturating), raising a sticky fault at ERR_LIMIT errors.
// Ports: i_clk, i_rst (sync, active-high), i_en, i_clear, i_j, i_k, i_q in;
//        o_locked, o_exp_q, o_mismatch, o_err_cnt, o_sample_cnt, o_fault out.
module jk_ff_monitor
  import jk_ff_monitor_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int ERR_LIMIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clear,
  input  logic             i_j,
  input  logic             i_k,
  input  logic             i_q,
  output logic             o_locked,
  output logic             o_exp_q,
  output logic             o_mismatch,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_sample_cnt,
  output logic             o_fault
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(ERR_LIMIT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_e           r_state;
  logic             r_j;
  logic             r_k;
  logic             r_q;
  logic             r_locked;
  logic             r_mismatch;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_sample_cnt;
  logic             r_fault;

  logic             w_exp_q;
  logic             w_miss;
  logic [CNT_W-1:0] w_err_inc;
  logic [CNT_W-1:0] w_samp_inc;

  jk_predict u_predict (
    .i_q_r   (r_q),
    .i_j_r   (r_j),
    .i_k_r   (r_k),
    .o_exp_q (w_exp_q)
  );

  assign w_miss     = (i_q != w_exp_q);
  assign w_err_inc  = (r_err_cnt == CNT_MAX) ? r_err_cnt : r_err_cnt + ONE;
  assign w_samp_inc = (r_sample_cnt == CNT_MAX) ? r_sample_cnt : r_sample_cnt + ONE;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_j          <= 1'b0;
      r_k          <= 1'b0;
      r_q          <= 1'b0;
      r_locked     <= 1'b0;
      r_mismatch   <= 1'b0;
      r_err_cnt    <= '0;
      r_sample_cnt <= '0;
      r_fault      <= 1'b0;
    end else begin
      r_mismatch <= 1'b0;
      if (i_clear) begin
        // Clear wins over any compare this cycle; the next capture re-locks.
        r_err_cnt    <= '0;
        r_sample_cnt <= '0;
        r_fault      <= 1'b0;
        r_locked     <= 1'b0;
        r_state      <= i_en ? ST_SYNC : ST_IDLE;
      end else if (!i_en) begin
        r_locked <= 1'b0;
        r_state  <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_SYNC;
          ST_SYNC: begin
            r_j      <= i_j;
            r_k      <= i_k;
            r_q      <= i_q;
            r_locked <= 1'b1;
            r_state  <= ST_TRACK;
          end
          ST_TRACK: begin
            r_sample_cnt <= w_samp_inc;
            if (w_miss) begin
              r_mismatch <= 1'b1;
              r_err_cnt  <= w_err_inc;
              if (w_err_inc >= LIMIT) r_fault <= 1'b1;
            end
            // Reload from the observed q so a single bad cycle counts once.
            r_j <= i_j;
            r_k <= i_k;
            r_q <= i_q;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_locked     = r_locked;
  assign o_exp_q      = w_exp_q;
  assign o_mismatch   = r_mismatch;
  assign o_err_cnt    = r_err_cnt;
  assign o_sample_cnt = r_sample_cnt;
  assign o_fault      = r_fault;

endmodule
